// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and the logic around it:
// lock flag and status-clear in, PLL/fabric resets and status out.
interface pll_reset_sequencer_if #(
   parameter int EVT_W = 8
);
   logic             locked;
   logic             clr_status;
   logic             pll_rst;
   logic             sys_rst;
   logic             lock_lost;
   logic [EVT_W-1:0] relock_count;
   logic [EVT_W-1:0] timeout_count;
   logic [1:0]       state_dbg;

   // Sequencer side
   modport master (
      input  locked, clr_status,
      output pll_rst, sys_rst, lock_lost, relock_count, timeout_count, state_dbg
   );

   // PLL wrapper / software side
   modport slave (
      output locked, clr_status,
      input  pll_rst, sys_rst, lock_lost, relock_count, timeout_count, state_dbg
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a continuously stable
// lock, then releases the fabric reset. Any runtime lock loss forces a full
// PLL reset and is recorded in sticky status and saturating event counters.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CNT_W              = 24,
   parameter int EVT_W              = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   pll_reset_sequencer_if.master  seq_if
);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, locked_s_q;
   logic             pll_rst_q, sys_rst_q, lock_lost_q;
   logic [EVT_W-1:0] relock_q, timeout_q;
   logic             timeout_evt, lost_evt;

   // Two-flop synchronizer bringing the asynchronous lock flag into refclk
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value; with blocking here locked would skip the second stage.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= seq_if.locked;
         locked_s_q <= sync1_q;
      end
   end

   // Next-state, dwell counter and event decode from the synchronized lock
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      timeout_evt = 1'b0;
      lost_evt    = 1'b0;
      case (state_q)
         PLL_RESET: begin
            if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s_q) begin
               state_d = STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d     = PLL_RESET;
               timeout_evt = 1'b1;
            end
         end
         STABLE: begin
            if (!locked_s_q)                state_d = WAIT_LOCK;
            else if (cnt_q == STABLE_LAST)  state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q;
            if (!locked_s_q) begin
               state_d  = PLL_RESET;
               lost_evt = 1'b1;
            end
         end
         default: state_d = PLL_RESET;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // State, registered reset decodes and sticky status / event counters
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= PLL_RESET;
         cnt_q       <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         lock_lost_q <= 1'b0;
         relock_q    <= '0;
         timeout_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         // Decoded from next state so the outputs come straight off flops
         pll_rst_q <= (state_d == PLL_RESET);
         sys_rst_q <= (state_d != RUN);
         if (seq_if.clr_status) begin
            // A coincident event survives the clear
            lock_lost_q <= lost_evt;
            relock_q    <= EVT_W'(lost_evt);
            timeout_q   <= EVT_W'(timeout_evt);
         end else begin
            if (lost_evt) lock_lost_q <= 1'b1;
            if (lost_evt && (relock_q != '1))    relock_q  <= relock_q + 1'b1;
            if (timeout_evt && (timeout_q != '1)) timeout_q <= timeout_q + 1'b1;
         end
      end
   end

   assign seq_if.pll_rst       = pll_rst_q;
   assign seq_if.sys_rst       = sys_rst_q;
   assign seq_if.lock_lost     = lock_lost_q;
   assign seq_if.relock_count  = relock_q;
   assign seq_if.timeout_count = timeout_q;
   assign seq_if.state_dbg     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed scenarios followed by random
// lock/clear/reset stimulus, all compared against a timestamp-based model.
module tb_pll_reset_sequencer;

   localparam int PRC   = 4;
   localparam int TO    = 20;
   localparam int ST    = 8;
   localparam int CNT_W = 8;
   localparam int EVT_W = 2;
   localparam int EMAX  = (1 << EVT_W) - 1;

   logic clk;
   logic rst;

   pll_reset_sequencer_if #(.EVT_W(EVT_W)) bus ();

   pll_reset_sequencer #(
      .PLL_RST_CYCLES     (PRC),
      .LOCK_TIMEOUT       (TO),
      .LOCK_STABLE_CYCLES (ST),
      .CNT_W              (CNT_W),
      .EVT_W              (EVT_W)
   ) dut (
      .refclk (clk),
      .rst    (rst),
      .seq_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: phase plus the edge number at which it was entered;
   // each phase ends after a fixed number of edges measured from entry.
   int m_phase, m_entry, m_edge;
   int m_relock, m_tout;
   int m_lost;
   bit sync_q[$];

   function automatic void model_reset();
      m_phase  = 0;
      m_edge   = 0;
      m_entry  = 0;
      m_relock = 0;
      m_tout   = 0;
      m_lost   = 0;
      sync_q   = '{1'b0, 1'b0};
   endfunction

   function automatic void model_edge(input bit lk, input bit clr);
      bit ls;
      int age, nxt, tev, lev;
      m_edge++;
      ls = sync_q.pop_front();
      sync_q.push_back(lk);
      age = m_edge - m_entry;
      nxt = m_phase;
      tev = 0;
      lev = 0;
      case (m_phase)
         0: if (age == PRC) nxt = 1;
         1: if (ls) nxt = 2;
            else if (age == TO) begin nxt = 0; tev = 1; end
         2: if (!ls) nxt = 1;
            else if (age == ST) nxt = 3;
         default: if (!ls) begin nxt = 0; lev = 1; end
      endcase
      if (nxt != m_phase) begin
         m_phase = nxt;
         m_entry = m_edge;
      end
      if (clr) begin
         m_lost   = lev;
         m_relock = lev;
         m_tout   = tev;
      end else begin
         if (lev != 0) m_lost = 1;
         m_relock = (m_relock + lev > EMAX) ? EMAX : m_relock + lev;
         m_tout   = (m_tout + tev > EMAX) ? EMAX : m_tout + tev;
      end
   endfunction

   task automatic compare_model();
      check("pll_rst",       int'(bus.pll_rst),       (m_phase == 0) ? 1 : 0);
      check("sys_rst",       int'(bus.sys_rst),       (m_phase == 3) ? 0 : 1);
      check("state_dbg",     int'(bus.state_dbg),     m_phase);
      check("lock_lost",     int'(bus.lock_lost),     m_lost);
      check("relock_count",  int'(bus.relock_count),  m_relock);
      check("timeout_count", int'(bus.timeout_count), m_tout);
   endtask

   // Drive inputs just after a falling edge, take one rising edge, then
   // compare on the following falling edge.
   task automatic step(input bit lk, input bit clr);
      bus.locked     = lk;
      bus.clr_status = clr;
      @(posedge clk);
      model_edge(lk, clr);
      @(negedge clk);
      compare_model();
   endtask

   // Asynchronous reset between edges; outputs must clear with no clock edge
   task automatic async_reset(input string tag);
      #1 rst = 1'b1;
      #1;
      check({tag, "_pll_rst"},   int'(bus.pll_rst),       1);
      check({tag, "_sys_rst"},   int'(bus.sys_rst),       1);
      check({tag, "_state"},     int'(bus.state_dbg),     0);
      check({tag, "_lock_lost"}, int'(bus.lock_lost),     0);
      check({tag, "_relock"},    int'(bus.relock_count),  0);
      check({tag, "_timeout"},   int'(bus.timeout_count), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit seg_val;
      int seg_len;
      bit reached;
      rst            = 1'b1;
      bus.locked     = 1'b0;
      bus.clr_status = 1'b0;
      model_reset();
      @(negedge clk);
      compare_model();
      rst = 1'b0;

      // Locked from reset: pll_rst falls after edge 4, sys_rst after edge 13
      for (int e = 1; e <= 13; e++) begin
         step(1'b1, 1'b0);
         if (e == 3)  check("t1_pll_rst_e3", int'(bus.pll_rst), 1);
         if (e == 4)  check("t1_pll_rst_e4", int'(bus.pll_rst), 0);
         if (e == 12) check("t1_sys_rst_e12", int'(bus.sys_rst), 1);
         if (e == 13) begin
            check("t1_sys_rst_e13", int'(bus.sys_rst), 0);
            check("t1_state_e13", int'(bus.state_dbg), 3);
         end
      end

      // Lock drop in RUN coincident with a status clear
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("t4_sys_rst_held", int'(bus.sys_rst), 0);
      step(1'b0, 1'b1);
      check("t5_lost_clr", int'(bus.lock_lost), 1);
      check("t5_relock_clr", int'(bus.relock_count), 1);
      check("t5_timeout_clr", int'(bus.timeout_count), 0);
      check("t4_sys_rst_up", int'(bus.sys_rst), 1);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0);
         check("t4_pll_rst_pulse", int'(bus.pll_rst), (i < 4) ? 1 : 0);
      end
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
      check("t4_relock_run", int'(bus.sys_rst), 0);
      check("t4_lost_sticky", int'(bus.lock_lost), 1);

      // Clear alone
      step(1'b1, 1'b1);
      check("t5_clear_lost", int'(bus.lock_lost), 0);
      check("t5_clear_relock", int'(bus.relock_count), 0);

      // No lock: repeated timeouts saturate the counter
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
      check("t2_timeout_sat", int'(bus.timeout_count), EMAX);
      check("t2_sys_rst", int'(bus.sys_rst), 1);

      // Reach STABLE, then reset asynchronously
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
         step(1'b1, 1'b0);
         if (bus.state_dbg == 2'd2) reached = 1'b1;
      end
      check("t6_reach_stable", int'(reached), 1);
      async_reset("t6");

      // Random lock segments, clears and occasional resets
      seg_len = 0;
      seg_val = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (seg_len == 0) begin
            seg_val = ($urandom_range(0, 3) != 0);
            seg_len = seg_val ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
         end
         seg_len--;
         if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
         else step(seg_val, $urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
